tile_config_loader: RTL and testbench
=====================================

# tile_config_loader

Parametrised configuration loader for one logic tile: a LANES-wide daisy-chainable shift register, a shadow (active) register that updates only on an explicit commit, a beat counter that rejects short loads, and a readback path that copies the active configuration back into the chain for verification. Sits between the tile's configuration chain pins and the tile's `config_in` bus, and replaces the fixed 146-bit single-lane shift register. The tile never sees a partially shifted configuration.

## Interface
- `CONFIG_WIDTH`, 146: configuration bits consumed by the tile.
- `LANES`, 1: bits shifted per beat. DEPTH = ceil(CONFIG_WIDTH/LANES). SR_WIDTH = DEPTH*LANES.

- `config_clock`  in  1: sole clock; all state updates on its rising edge.
- `config_nreset`  in  1: asynchronous, active-low reset.
- `config_enable`  in  1: shift strobe; one beat per cycle while high.
- `config_in`  in  LANES: serial data in, one lane per bit.
- `config_commit`  in  1: single-cycle request to copy the shift register into the shadow register.
- `config_readback`  in  1: single-cycle request to copy the shadow register into the shift register.
- `config_out`  out  LANES: `sr[SR_WIDTH-1 -: LANES]`, for the next tile in the chain.
- `config_data`  out  CONFIG_WIDTH: `shadow[CONFIG_WIDTH-1:0]`, to the tile.
- `config_valid`  out  1: shadow holds a committed configuration.
- `config_error`  out  1: last commit was rejected.

## Operation
- Shift: when `config_enable` is high, `sr <= {sr[SR_WIDTH-LANES-1:0], config_in}`. Padding bits (SR_WIDTH-CONFIG_WIDTH, at the top) pass through but are never exported. With LANES=1, behaviour matches the legacy chain: `config_out` equals `sr[CONFIG_WIDTH-1]`.
- Beat counter `cnt`, width clog2(DEPTH+1):
  - Increments on each shift beat and saturates at DEPTH.
  - Because bits for downstream tiles pass through, any count of DEPTH beats or more is acceptable.
- Load states, derived from `cnt`:
  - LOADING: `cnt` < DEPTH.
  - READY: `cnt` == DEPTH.
- Commit, when `config_commit` is high:
  - In READY: `shadow <= sr` (the pre-edge value), `config_valid <= 1`, `config_error <= 0`, `cnt <= 0`.
  - In LOADING: `shadow` and `config_valid` are unchanged, `config_error <= 1`, and `cnt` is unchanged.
- Readback, when `config_readback` is high and `config_commit` is low:
  - `sr <= shadow`, `cnt <= DEPTH` (READY). Shifting is suppressed that cycle.
  - The active configuration can then be shifted out on `config_out` or re-committed unchanged.
- Priority on simultaneous requests:
  - commit > readback; readback is dropped when both are high.
  - readback > enable; no shift occurs that cycle.
  - commit and enable together: the shift happens, and the commit uses the pre-shift `sr` and the pre-shift `cnt` for its check. `cnt` then becomes 0 on a successful commit, or the saturating increment on a failed one.
- `config_error` is sticky until the next successful commit or reset.
- Reset clears `sr`, `shadow`, `cnt`, `config_valid` and `config_error` to 0, so `config_out` and `config_data` are 0. A reset mid-load discards all shifted bits. A reset after a commit clears the tile configuration.

## Timing
- All outputs are registered or direct register slices; there are no combinational input-to-output paths.
- Data entering `config_in` on beat k appears on `config_out` after beat k+DEPTH-1 (a DEPTH-beat delay line).
- Commit latency: `config_data` and `config_valid` change on the edge that samples `config_commit`, and are visible the following cycle.
- Readback latency: the first shadow word (`shadow[SR_WIDTH-1 -: LANES]`) is on `config_out` immediately after the readback edge. Each following enable beat presents the next lower word.
- Back-to-back commits: the second commit fails, because `cnt` is 0 after the first.
- `config_enable` may toggle arbitrarily; only cycles where it is high are counted.

## Test plan
- Reset, then shift 146 random bits with LANES=1 and commit → `config_data` equals the shifted pattern (first bit at bit 145), `config_valid`=1, `config_error`=0.
- Shift 145 bits, then commit → `config_error`=1, `config_valid`=0, `config_data`=0. Shift 1 more bit and commit → success, `config_error`=0.
- Chain of 2 loaders: shift 292 bits into the first → the second loader's `config_data` holds the first 146 bits and the first loader's holds the last 146. Commit both → both valid.
- LANES=4 (DEPTH=37, SR_WIDTH=148): load 37 beats and commit → `config_data` correct and the 2 padding bits ignored. Readback, then shift 37 beats → `config_out` reproduces the 37 loaded words in the same order.
- Simultaneous events: commit+readback in one cycle → commit only. commit+enable in READY → `shadow` holds the pre-shift `sr` and `cnt`=0.
- Assert `config_nreset` mid-shift (beat 70) and after a commit → all outputs are 0 asynchronously. The next 146-beat load and commit succeeds.

Source files
------------

// File: rtl/tile_config_loader_if.sv
// Configuration chain bundle between a chain driver (master) and a tile loader (slave).
interface tile_config_loader_if #(
    parameter int unsigned CONFIG_WIDTH = 146,
    parameter int unsigned LANES        = 1
);
    logic                    config_enable;
    logic [LANES-1:0]        config_in;
    logic                    config_commit;
    logic                    config_readback;
    logic [LANES-1:0]        config_out;
    logic [CONFIG_WIDTH-1:0] config_data;
    logic                    config_valid;
    logic                    config_error;

    modport master (
        output config_enable, config_in, config_commit, config_readback,
        input  config_out, config_data, config_valid, config_error
    );

    modport slave (
        input  config_enable, config_in, config_commit, config_readback,
        output config_out, config_data, config_valid, config_error
    );
endinterface

// File: rtl/tile_config_loader.sv
// LANES-wide chainable config shift register with commit-gated shadow copy,
// short-load rejection and shadow-to-chain readback.
module tile_config_loader #(
    parameter int unsigned CONFIG_WIDTH = 146,
    parameter int unsigned LANES        = 1
) (
    input  logic                  config_clock,
    input  logic                  config_nreset,
    tile_config_loader_if.slave   cfg
);
    localparam int unsigned DEPTH    = (CONFIG_WIDTH + LANES - 1) / LANES;
    localparam int unsigned SR_WIDTH = DEPTH * LANES;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [0:0] ST_LOADING = 1'b0;
    localparam logic [0:0] ST_READY   = 1'b1;

    logic [SR_WIDTH-1:0] sr,     sr_nxt;
    logic [SR_WIDTH-1:0] shadow, shadow_nxt;
    logic [CNT_W-1:0]    cnt,    cnt_nxt;
    logic                valid,  valid_nxt;
    logic                error,  error_nxt;

    logic [0:0]          load_state_c;
    logic [SR_WIDTH-1:0] sr_shifted_c;
    logic [CNT_W-1:0]    cnt_inc_c;

    // Load state is a pure function of the beat count; padding words keep cnt saturated.
    assign load_state_c = (cnt == CNT_FULL) ? ST_READY : ST_LOADING;
    assign sr_shifted_c = SR_WIDTH'({sr, cfg.config_in});
    assign cnt_inc_c    = (load_state_c == ST_READY) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge config_clock or negedge config_nreset) begin
        if (!config_nreset) begin
            sr     <= '0;
            shadow <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            error  <= 1'b0;
        end else begin
            sr     <= sr_nxt;
            shadow <= shadow_nxt;
            cnt    <= cnt_nxt;
            valid  <= valid_nxt;
            error  <= error_nxt;
        end
    end

    // Commit checks the pre-edge sr/cnt; a concurrent shift still happens. Readback loses to commit.
    always_comb begin
        sr_nxt     = sr;
        shadow_nxt = shadow;
        cnt_nxt    = cnt;
        valid_nxt  = valid;
        error_nxt  = error;

        if (cfg.config_commit) begin
            if (cfg.config_enable) begin
                sr_nxt  = sr_shifted_c;
                cnt_nxt = cnt_inc_c;
            end
            if (load_state_c == ST_READY) begin
                shadow_nxt = sr;
                valid_nxt  = 1'b1;
                error_nxt  = 1'b0;
                cnt_nxt    = '0;
            end else begin
                error_nxt  = 1'b1;
            end
        end else if (cfg.config_readback) begin
            sr_nxt  = shadow;
            cnt_nxt = CNT_FULL;
        end else if (cfg.config_enable) begin
            sr_nxt  = sr_shifted_c;
            cnt_nxt = cnt_inc_c;
        end
    end

    assign cfg.config_out   = sr[SR_WIDTH-1 -: LANES];
    assign cfg.config_data  = shadow[CONFIG_WIDTH-1:0];
    assign cfg.config_valid = valid;
    assign cfg.config_error = error;
endmodule

// File: tb/tb_tile_config_loader.sv
// Directed bench: two chained single-lane loaders plus one 4-lane loader, scoreboard-checked.
module tb_tile_config_loader;
    localparam int unsigned CW = 146;

    typedef struct {
        string        tag;
        logic [147:0] val;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [CW-1:0]  exp_a;
    logic [CW-1:0]  exp_b;
    logic [147:0]   exp_w;
    logic [CW-1:0]  snap;
    logic [3:0]     w [37];
    logic           bit_x;

    always #5 clk = ~clk;

    tile_config_loader_if #(.CONFIG_WIDTH(CW), .LANES(1)) bus_a ();
    tile_config_loader_if #(.CONFIG_WIDTH(CW), .LANES(1)) bus_b ();
    tile_config_loader_if #(.CONFIG_WIDTH(CW), .LANES(4)) bus_w ();

    assign bus_b.config_in     = bus_a.config_out;
    assign bus_b.config_enable = bus_a.config_enable;

    tile_config_loader #(.CONFIG_WIDTH(CW), .LANES(1)) u_a (
        .config_clock(clk), .config_nreset(rst_n), .cfg(bus_a.slave));
    tile_config_loader #(.CONFIG_WIDTH(CW), .LANES(1)) u_b (
        .config_clock(clk), .config_nreset(rst_n), .cfg(bus_b.slave));
    tile_config_loader #(.CONFIG_WIDTH(CW), .LANES(4)) u_w (
        .config_clock(clk), .config_nreset(rst_n), .cfg(bus_w.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [147:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [147:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_a.config_enable = 1'b0; bus_a.config_in = '0;
        bus_a.config_commit = 1'b0; bus_a.config_readback = 1'b0;
        bus_b.config_commit = 1'b0; bus_b.config_readback = 1'b0;
        bus_w.config_enable = 1'b0; bus_w.config_in = '0;
        bus_w.config_commit = 1'b0; bus_w.config_readback = 1'b0;
        exp_a = '0;
        exp_b = '0;
        exp_w = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Reference delay lines: b receives the bit falling out of a's top.
    task automatic shift_a(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom);
            bus_a.config_in     = b;
            bus_a.config_enable = 1'b1;
            tick();
            exp_b = {exp_b[CW-2:0], exp_a[CW-1]};
            exp_a = {exp_a[CW-2:0], b};
        end
        bus_a.config_enable = 1'b0;
    endtask

    task automatic commit_a();
        bus_a.config_commit = 1'b1;
        tick();
        bus_a.config_commit = 1'b0;
    endtask

    task automatic check_a(input string pfx, input logic [CW-1:0] d, input logic v, input logic er);
        expect_val({pfx, "_data"},  148'(d));
        expect_val({pfx, "_valid"}, 148'(v));
        expect_val({pfx, "_error"}, 148'(er));
        check(148'(bus_a.config_data));
        check(148'(bus_a.config_valid));
        check(148'(bus_a.config_error));
    endtask

    initial begin
        do_reset();
        expect_val("rst_out", 148'(0));
        check(148'(bus_a.config_out));
        check_a("rst", '0, 1'b0, 1'b0);

        // Full single-lane load then commit
        shift_a(146);
        expect_val("full_out", 148'(exp_a[CW-1]));
        check(148'(bus_a.config_out));
        commit_a();
        check_a("full", exp_a, 1'b1, 1'b0);

        // Short load rejected, one more beat accepted, immediate re-commit rejected
        do_reset();
        shift_a(145);
        commit_a();
        check_a("short", '0, 1'b0, 1'b1);
        shift_a(1);
        commit_a();
        check_a("short_fix", exp_a, 1'b1, 1'b0);
        snap = exp_a;
        commit_a();
        check_a("b2b", snap, 1'b1, 1'b1);

        // Two-tile chain
        do_reset();
        shift_a(292);
        bus_a.config_commit = 1'b1;
        bus_b.config_commit = 1'b1;
        tick();
        bus_a.config_commit = 1'b0;
        bus_b.config_commit = 1'b0;
        check_a("chain_a", exp_a, 1'b1, 1'b0);
        expect_val("chain_b_data",  148'(exp_b));
        expect_val("chain_b_valid", 148'(1));
        check(148'(bus_b.config_data));
        check(148'(bus_b.config_valid));

        // Commit + readback: commit wins, cnt cleared so the next commit fails
        shift_a(146);
        bus_a.config_commit   = 1'b1;
        bus_a.config_readback = 1'b1;
        tick();
        bus_a.config_commit   = 1'b0;
        bus_a.config_readback = 1'b0;
        check_a("cr", exp_a, 1'b1, 1'b0);
        expect_val("cr_out", 148'(exp_a[CW-1]));
        check(148'(bus_a.config_out));
        snap = exp_a;
        commit_a();
        check_a("cr_next", snap, 1'b1, 1'b1);

        // Commit + enable in READY: shadow takes pre-shift sr, shift still happens
        shift_a(146);
        snap  = exp_a;
        bit_x = 1'($urandom);
        bus_a.config_in     = bit_x;
        bus_a.config_enable = 1'b1;
        bus_a.config_commit = 1'b1;
        tick();
        bus_a.config_enable = 1'b0;
        bus_a.config_commit = 1'b0;
        exp_b = {exp_b[CW-2:0], exp_a[CW-1]};
        exp_a = {exp_a[CW-2:0], bit_x};
        check_a("ce", snap, 1'b1, 1'b0);
        expect_val("ce_out", 148'(exp_a[CW-1]));
        check(148'(bus_a.config_out));
        commit_a();
        check_a("ce_next", snap, 1'b1, 1'b1);

        // Readback restores the active config and makes it committable again
        bus_a.config_readback = 1'b1;
        tick();
        bus_a.config_readback = 1'b0;
        exp_a = snap;
        expect_val("rb_out", 148'(snap[CW-1]));
        check(148'(bus_a.config_out));
        commit_a();
        check_a("rb_commit", snap, 1'b1, 1'b0);

        // Four-lane load, commit, readback and shift-out
        do_reset();
        for (int j = 0; j < 37; j++) begin
            w[j] = 4'($urandom);
            bus_w.config_in     = w[j];
            bus_w.config_enable = 1'b1;
            tick();
            exp_w = {exp_w[143:0], w[j]};
        end
        bus_w.config_enable = 1'b0;
        bus_w.config_commit = 1'b1;
        tick();
        bus_w.config_commit = 1'b0;
        expect_val("w_data",  148'(exp_w[145:0]));
        expect_val("w_valid", 148'(1));
        expect_val("w_error", 148'(0));
        check(148'(bus_w.config_data));
        check(148'(bus_w.config_valid));
        check(148'(bus_w.config_error));
        bus_w.config_readback = 1'b1;
        tick();
        bus_w.config_readback = 1'b0;
        expect_val("w_rb0", 148'(w[0]));
        check(148'(bus_w.config_out));
        bus_w.config_in = 4'h0;
        for (int j = 1; j < 37; j++) begin
            bus_w.config_enable = 1'b1;
            tick();
            expect_val($sformatf("w_rb%0d", j), 148'(w[j]));
            check(148'(bus_w.config_out));
        end
        bus_w.config_enable = 1'b0;

        // Reset mid-load discards the beat count
        do_reset();
        shift_a(70);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_a = '0;
        exp_b = '0;
        tick();
        shift_a(76);
        commit_a();
        check_a("midrst", '0, 1'b0, 1'b1);
        shift_a(70);
        commit_a();
        check_a("midrst_fix", exp_a, 1'b1, 1'b0);

        // Asynchronous reset after a commit clears everything before any edge
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("arst_out", 148'(0));
        check(148'(bus_a.config_out));
        check_a("arst", '0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        exp_a = '0;
        exp_b = '0;
        tick();
        shift_a(146);
        commit_a();
        check_a("post_rst", exp_a, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
